pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit_pkg.sv | 29 ++
 rtl/pc_fetch_unit_next_pc_mux.sv | 42 ++++
 rtl/pc_fetch_unit.sv | 100 ++++++++++
 tb/tb_pc_fetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared core definitions for the fetch stage: FSM encodings, redirect
// selection codes, the canonical NOP and the default boot address.
package pc_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;
  localparam logic [31:0] FETCH_STRIDE      = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_t;

  // Outcome of the next-address priority chain, highest priority first.
  typedef enum logic [2:0] {
    SEL_TRAP   = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_STALL  = 3'd2,
    SEL_WAIT   = 3'd3,
    SEL_INC    = 3'd4
  } next_sel_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_mux.sv
// Combinational next-fetch-address selection: trap, branch, hold or
// sequential increment, plus the branch misalignment flag.
module next_pc_mux
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] cur_addr,
  input  logic        ms_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] target_addr,
  input  logic        trap_taken,
  input  logic [31:0] trap_addr,
  output logic [31:0] next_addr,
  output next_sel_t   sel,
  output logic        branch_misaligned
);

  // NOTE: every output gets a default before the priority chain so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    next_addr         = cur_addr;
    sel               = SEL_INC;
    branch_misaligned = 1'b0;

    if (trap_taken) begin
      sel       = SEL_TRAP;
      next_addr = trap_addr;
    end else if (branch_taken && !stall) begin
      sel               = SEL_BRANCH;
      next_addr         = align_word(target_addr);
      branch_misaligned = target_addr[1];
    end else if (stall) begin
      sel = SEL_STALL;
    end else if (!ms_ready) begin
      sel = SEL_WAIT;
    end else begin
      // 32-bit add wraps naturally from 32'hFFFF_FFFC to 32'h0000_0000.
      next_addr = cur_addr + FETCH_STRIDE;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: boot sequencing, memory request address,
// one-cycle capture into the decode-side registers, and redirect flushing.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = DEFAULT_BOOT_ADDR
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ms_ready_in,
  input  logic [31:0] instr_in,
  input  logic        stall_in,
  input  logic        branch_taken_in,
  input  logic [31:0] target_addr_in,
  input  logic        trap_taken_in,
  input  logic [31:0] trap_addr_in,
  output logic [31:0] imaddr_out,
  output logic        imreq_out,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid_out,
  output logic        misaligned_instr_out
);

  fetch_state_t state_q, state_d;
  next_sel_t    sel;
  logic [31:0]  next_addr;
  logic         branch_misaligned;

  next_pc_mux u_next_pc_mux (
    .cur_addr          (imaddr_out),
    .ms_ready          (ms_ready_in),
    .stall             (stall_in),
    .branch_taken      (branch_taken_in),
    .target_addr       (target_addr_in),
    .trap_taken        (trap_taken_in),
    .trap_addr         (trap_addr_in),
    .next_addr         (next_addr),
    .sel               (sel),
    .branch_misaligned (branch_misaligned)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  // FETCH, WAIT and FLUSH all act on the same priority chain; the state only
  // records how the current address was reached.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_BOOT) begin
      state_d = ST_FETCH;
    end else begin
      unique case (sel)
        SEL_TRAP, SEL_BRANCH: state_d = ST_FLUSH;
        SEL_STALL:            state_d = state_q;
        SEL_WAIT:             state_d = ST_WAIT;
        SEL_INC:              state_d = ST_FETCH;
        default:              state_d = state_q;
      endcase
    end
  end

  assign imreq_out = (state_q != ST_BOOT);

  // NOTE: reset clears every register here; an in-flight fetch is simply
  // dropped because nothing captures instr_in until FETCH is re-entered.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      imaddr_out           <= BOOT_ADDR;
      pc_out               <= BOOT_ADDR;
      instr_out            <= NOP_INSTR;
      instr_valid_out      <= 1'b0;
      misaligned_instr_out <= 1'b0;
    end else if (state_q == ST_BOOT) begin
      imaddr_out           <= BOOT_ADDR;
      misaligned_instr_out <= 1'b0;
    end else begin
      imaddr_out           <= next_addr;
      misaligned_instr_out <= (sel == SEL_BRANCH) && branch_misaligned;
      unique case (sel)
        SEL_TRAP, SEL_BRANCH: begin
          instr_out       <= NOP_INSTR;
          instr_valid_out <= 1'b0;
        end
        SEL_WAIT: instr_valid_out <= 1'b0;
        SEL_INC: begin
          pc_out          <= imaddr_out;
          instr_out       <= instr_in;
          instr_valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_pc_fetch_unit;

  localparam logic [31:0] BOOT = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        ms_ready_in;
  logic [31:0] instr_in;
  logic        stall_in;
  logic        branch_taken_in;
  logic [31:0] target_addr_in;
  logic        trap_taken_in;
  logic [31:0] trap_addr_in;
  logic [31:0] imaddr_out;
  logic        imreq_out;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid_out;
  logic        misaligned_instr_out;

  pc_fetch_unit #(.BOOT_ADDR(BOOT)) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .ms_ready_in          (ms_ready_in),
    .instr_in             (instr_in),
    .stall_in             (stall_in),
    .branch_taken_in      (branch_taken_in),
    .target_addr_in       (target_addr_in),
    .trap_taken_in        (trap_taken_in),
    .trap_addr_in         (trap_addr_in),
    .imaddr_out           (imaddr_out),
    .imreq_out            (imreq_out),
    .pc_out               (pc_out),
    .instr_out            (instr_out),
    .instr_valid_out      (instr_valid_out),
    .misaligned_instr_out (misaligned_instr_out)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  // Reference model: the architectural view of the fetch stage.
  bit          m_booted;
  logic [31:0] m_addr, m_pc, m_instr;
  logic        m_valid, m_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("imaddr", imaddr_out, m_addr);
    check("imreq", {31'd0, imreq_out}, {31'd0, m_booted});
    check("pc", pc_out, m_pc);
    check("instr", instr_out, m_instr);
    check("valid", {31'd0, instr_valid_out}, {31'd0, m_valid});
    check("misaligned", {31'd0, misaligned_instr_out}, {31'd0, m_mis});
  endtask

  task automatic model_reset();
    m_booted = 1'b0;
    m_addr   = BOOT;
    m_pc     = BOOT;
    m_instr  = NOP;
    m_valid  = 1'b0;
    m_mis    = 1'b0;
  endtask

  // One rising edge of the spec's rules, written as plain priorities.
  task automatic model_edge();
    m_mis = 1'b0;
    if (!m_booted) begin
      m_booted = 1'b1;
    end else if (trap_taken_in) begin
      m_addr  = trap_addr_in;
      m_instr = NOP;
      m_valid = 1'b0;
    end else if (branch_taken_in && !stall_in) begin
      m_addr  = {target_addr_in[31:2], 2'b00};
      m_instr = NOP;
      m_valid = 1'b0;
      m_mis   = target_addr_in[1];
    end else if (stall_in) begin
      // everything frozen
    end else if (!ms_ready_in) begin
      m_valid = 1'b0;
    end else begin
      m_pc    = m_addr;
      m_instr = instr_in;
      m_valid = 1'b1;
      m_addr  = m_addr + 32'd4;
    end
  endtask

  task automatic drive(input logic rdy, input logic stl, input logic br,
                       input logic [31:0] tgt, input logic tr, input logic [31:0] taddr);
    ms_ready_in     = rdy;
    stall_in        = stl;
    branch_taken_in = br;
    target_addr_in  = tgt;
    trap_taken_in   = tr;
    trap_addr_in    = taddr;
    instr_in        = $urandom;
  endtask

  task automatic cycle();
    @(posedge clk_in);
    if (!rst_in) model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rst_in = 1'b1;
    model_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check_all();
    cycle();
    cycle();

    // Reset release: 0, 4, 8 with pc trailing by one.
    rst_in = 1'b0;
    cycle();
    check("boot_addr", imaddr_out, 32'h0);
    check("boot_req", {31'd0, imreq_out}, 32'd1);
    cycle();
    check("seq_addr4", imaddr_out, 32'h4);
    check("seq_pc0", pc_out, 32'h0);
    cycle();
    check("seq_addr8", imaddr_out, 32'h8);
    check("seq_pc4", pc_out, 32'h4);

    // Aligned branch: one NOP bubble then the target instruction.
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    cycle();
    check("br_addr", imaddr_out, 32'h100);
    check("br_bubble", instr_out, NOP);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle();
    check("br_pc", pc_out, 32'h100);
    check("br_valid", {31'd0, instr_valid_out}, 32'd1);

    // Trap beats a simultaneous branch.
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200);
    cycle();
    check("trap_addr", imaddr_out, 32'h200);
    check("trap_mis", {31'd0, misaligned_instr_out}, 32'd0);

    // Misaligned branch taken during FLUSH: redirect overrides, flag pulses once.
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0102, 1'b0, 32'h0);
    cycle();
    check("mis_addr", imaddr_out, 32'h100);
    check("mis_pulse", {31'd0, misaligned_instr_out}, 32'd1);

    // Memory not ready for three cycles.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("mis_clear_pre", {31'd0, misaligned_instr_out}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("wait_addr", imaddr_out, 32'h100);
      check("wait_valid", {31'd0, instr_valid_out}, 32'd0);
    end
    check("mis_gone", {31'd0, misaligned_instr_out}, 32'd0);

    // Stall for two cycles with ready: everything frozen.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      cycle();
      check("stall_addr", imaddr_out, 32'h100);
      check("stall_valid", {31'd0, instr_valid_out}, 32'd0);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle();
    check("resume_pc", pc_out, 32'h100);

    // Address wrap at the top of the space.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    cycle();
    check("wrap_top", imaddr_out, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle();
    check("wrap_zero", imaddr_out, 32'h0);
    check("wrap_pc", pc_out, 32'hFFFF_FFFC);

    // Asynchronous reset in the middle of a cycle.
    cycle();
    #2;
    rst_in = 1'b1;
    model_reset();
    #1;
    check_all();
    cycle();
    rst_in = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(99) < 75), ($urandom_range(99) < 20),
            ($urandom_range(99) < 10), $urandom, ($urandom_range(99) < 5), $urandom);
      if ($urandom_range(199) == 0) begin
        #2;
        rst_in = 1'b1;
        model_reset();
        #1;
        check_all();
        cycle();
        rst_in = 1'b0;
      end else begin
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
